// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display driver.
package seg7_pkg;

    typedef logic [7:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t SEG_DASH  = 8'h40;

    // Segment patterns for digits 0-9, bit order dp,g,f,e,d,c,b,a.
    localparam seg_t GLYPH [10] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

endpackage

// File: rtl/seg7_glyph_decoder.sv
// BCD digit plus decimal point to active-high segment pattern.
// Codes above 9 show a dash so corrupted data is visible rather than dark.
module seg7_glyph_decoder
    import seg7_pkg::*;
(
    input  bcd_t i_bcd,
    input  logic i_dp,
    output seg_t o_seg
);

    seg_t w_seg;

    // Table lookup for valid digits, dash otherwise; dp overrides bit 7.
    always_comb begin
        w_seg = SEG_DASH;
        if (i_bcd <= 4'd9) begin
            w_seg = GLYPH[i_bcd];
        end
        w_seg[7] = i_dp;
    end

    assign o_seg = w_seg;

endmodule

// File: rtl/seg7_mux_display.sv
// Time-multiplexed N-digit 7-segment driver with per-slot PWM brightness,
// leading-zero suppression and frame-synchronous (tear-free) data update.
module seg7_mux_display
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int DIGIT_RATE = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_bcd_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_load,
    input  logic [BRIGHT_W-1:0]     i_brightness,
    input  logic                    i_lz_blank,
    output logic [7:0]              o_seg_out,
    output logic [NUM_DIGITS-1:0]   o_digit_sel,
    output logic                    o_frame_done
);

    localparam int LEVELS  = 2**BRIGHT_W - 1;
    localparam int SUB_CYC = CLK_FREQ / (DIGIT_RATE * LEVELS);
    localparam int SC_W    = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
    localparam int DG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SC_W-1:0]     SUB_LAST = SC_W'(SUB_CYC - 1);
    localparam logic [BRIGHT_W-1:0] LVL_LAST = BRIGHT_W'(LEVELS - 1);
    localparam logic [DG_W-1:0]     DIG_LAST = DG_W'(NUM_DIGITS - 1);

    generate
        if (SUB_CYC < 1) begin : g_bad_rate
            $error("seg7_mux_display: CLK_FREQ too low for DIGIT_RATE*LEVELS");
        end
    endgenerate

    // sub_idx never exceeds LEVELS-1 = 2**BRIGHT_W-2, so BRIGHT_W bits suffice
    // and it compares directly against the brightness level.
    logic [SC_W-1:0]         r_sub_cnt;
    logic [BRIGHT_W-1:0]     r_sub_idx;
    logic [DG_W-1:0]         r_digit_idx;
    logic [BRIGHT_W-1:0]     r_bright_lat;

    logic [4*NUM_DIGITS-1:0] r_active_bcd;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic                    r_pending;

    logic [7:0]              r_seg_out;
    logic [NUM_DIGITS-1:0]   r_digit_sel;

    logic                    w_slot_start;
    logic                    w_boundary;
    logic                    w_apply;
    logic [4*NUM_DIGITS-1:0] w_bcd_eff;
    logic [NUM_DIGITS-1:0]   w_dp_eff;
    logic [BRIGHT_W-1:0]     w_bright_eff;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_zero_run;
    bcd_t                    w_cur_bcd;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    seg_t                    w_glyph;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;

    assign w_slot_start = i_enable && (r_sub_cnt == '0) && (r_sub_idx == '0);
    assign w_boundary   = w_slot_start && (r_digit_idx == '0);
    assign w_apply      = w_boundary && r_pending;

    // On the boundary cycle the output path already sees the shadow data, so
    // the first cycle of a new frame is never drawn with the old value.
    assign w_bcd_eff    = w_apply ? r_shadow_bcd : r_active_bcd;
    assign w_dp_eff     = w_apply ? r_shadow_dp  : r_active_dp;

    // Same idea for brightness: the slot-start cycle uses the value being latched.
    assign w_bright_eff = w_slot_start ? i_brightness : r_bright_lat;
    assign w_lit        = (r_sub_idx < w_bright_eff);

    assign o_frame_done = i_enable && (r_digit_idx == DIG_LAST) &&
                          (r_sub_idx == LVL_LAST) && (r_sub_cnt == SUB_LAST);

    // Leading-zero mask: scan from the most significant digit while zero and no dp.
    always_comb begin
        w_lz_mask  = '0;
        w_zero_run = i_lz_blank;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run   = w_zero_run && (w_bcd_eff[4*i +: 4] == 4'd0) && !w_dp_eff[i];
            w_lz_mask[i] = w_zero_run;
        end
    end

    assign w_cur_bcd   = w_bcd_eff[4*r_digit_idx +: 4];
    assign w_cur_dp    = w_dp_eff[r_digit_idx];
    assign w_cur_blank = w_lz_mask[r_digit_idx];

    seg7_glyph_decoder u_glyph (
        .i_bcd (w_cur_bcd),
        .i_dp  (w_cur_dp),
        .o_seg (w_glyph)
    );

    // Next output values: digit enable follows PWM, segments also honour blanking.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_sel_nxt = '0;
        if (i_enable && w_lit) begin
            w_sel_nxt = NUM_DIGITS'(1) << r_digit_idx;
            if (!w_cur_blank) begin
                w_seg_nxt = w_glyph;
            end
        end
    end

    // Scan counters: sub-period cycle count carries into sub_idx, then digit_idx.
    always_ff @(posedge i_clk) begin
        if (!i_reset || !i_enable) begin
            r_sub_cnt   <= '0;
            r_sub_idx   <= '0;
            r_digit_idx <= '0;
        end else if (r_sub_cnt == SUB_LAST) begin
            r_sub_cnt <= '0;
            if (r_sub_idx == LVL_LAST) begin
                r_sub_idx   <= '0;
                r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_sub_idx <= r_sub_idx + 1'b1;
            end
        end else begin
            r_sub_cnt <= r_sub_cnt + 1'b1;
        end
    end

    // Brightness is latched once per slot so a mid-slot change cannot cut a pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_bright_lat <= '0;
        end else if (w_slot_start) begin
            r_bright_lat <= i_brightness;
        end
    end

    // Shadow/pending capture and frame-boundary transfer to active data.
    // A load on the boundary cycle lands in shadow and keeps pending set.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_active_bcd <= '0;
            r_active_dp  <= '0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_apply) begin
                r_active_bcd <= r_shadow_bcd;
                r_active_dp  <= r_shadow_dp;
            end
            if (i_load) begin
                r_shadow_bcd <= i_bcd_in;
                r_shadow_dp  <= i_dp_in;
                r_pending    <= 1'b1;
            end else if (w_apply) begin
                r_pending    <= 1'b0;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_seg_out   <= '0;
            r_digit_sel <= '0;
        end else begin
            r_seg_out   <= w_seg_nxt;
            r_digit_sel <= w_sel_nxt;
        end
    end

    assign o_seg_out   = r_seg_out;
    assign o_digit_sel = r_digit_sel;

endmodule
